// File: rtl/count_sequencer.sv
// Run/pause/direction/limit controller for the up/down display counter.
// Turns tick and button events into registered step/clear/load commands one cycle later.
module count_sequencer #(
    parameter int WIDTH      = 8,
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 255,
    parameter int LIMIT_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             btn_run,
    input  logic             btn_dir,
    input  logic             btn_clr,
    input  logic [WIDTH-1:0] q,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_clr,
    output logic             cnt_load,
    output logic [WIDTH-1:0] load_val,
    output logic [1:0]       state,
    output logic             at_limit
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        HOLD  = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    localparam int MODE_WRAP   = 0;
    localparam int MODE_BOUNCE = 1;

    state_t           state_q, state_d;
    logic             up_q, up_d;
    logic             en_q, en_d;
    logic             clr_q, clr_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic             at_limit_q, at_limit_d;

    logic             eff_up;
    logic             limit_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            up_q       <= 1'b1;
            en_q       <= 1'b0;
            clr_q      <= 1'b0;
            load_q     <= 1'b0;
            load_val_q <= '0;
            at_limit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            up_q       <= up_d;
            en_q       <= en_d;
            clr_q      <= clr_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
            at_limit_q <= at_limit_d;
        end
    end

    // A direction toggle arriving with a tick applies before the limit check,
    // so the step (or limit action) uses the new direction. Out-of-range q
    // naturally reads as "at limit" for the direction it has overshot.
    always_comb begin
        eff_up    = btn_dir ? ~up_q : up_q;
        limit_hit = eff_up ? (q >= MAX_Q) : (q <= MIN_Q);
    end

    always_comb begin
        state_d    = state_q;
        up_d       = up_q;
        en_d       = 1'b0;
        clr_d      = 1'b0;
        load_d     = 1'b0;
        load_val_d = '0;

        if (btn_clr) begin
            clr_d   = 1'b1;
            state_d = IDLE;
            up_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (btn_run) begin
                        state_d = RUN;
                    end else if (btn_dir) begin
                        up_d = ~up_q;
                    end
                end

                RUN: begin
                    if (btn_run) begin
                        state_d = PAUSE;
                    end else begin
                        up_d = eff_up;
                        if (tick_1hz) begin
                            if (!limit_hit) begin
                                en_d = 1'b1;
                            end else if (LIMIT_MODE == MODE_WRAP) begin
                                load_d     = 1'b1;
                                load_val_d = eff_up ? MIN_Q : MAX_Q;
                            end else if (LIMIT_MODE == MODE_BOUNCE) begin
                                up_d = ~eff_up;
                                en_d = 1'b1;
                            end else begin
                                state_d = HOLD;
                            end
                        end
                    end
                end

                PAUSE: begin
                    if (btn_run) begin
                        state_d = RUN;
                    end else if (btn_dir) begin
                        up_d = ~up_q;
                    end
                end

                HOLD: begin
                    if (btn_run) begin
                        state_d = PAUSE;
                    end else if (btn_dir) begin
                        up_d    = ~up_q;
                        state_d = RUN;
                    end
                end

                default: state_d = IDLE;
            endcase
        end

        at_limit_d = (state_d == HOLD);
    end

    assign cnt_en   = en_q;
    assign cnt_up   = up_q;
    assign cnt_clr  = clr_q;
    assign cnt_load = load_q;
    assign load_val = load_val_q;
    assign state    = state_q;
    assign at_limit = at_limit_q;

endmodule
